// File: rtl/regsel_decode_pipe.sv
// Register-select decode stage: Rn/Rm/Rt extraction, Reg2Loc select, writer scoreboard, valid/ready output register.
// Optional macro REGSEL_WB_BYPASS_EN lets a same-cycle writeback mask its busy bit out of the hazard check.
module regsel_decode_pipe #(
    parameter int INSTR_W     = 32,
    parameter int SEL_W       = 5,
    parameter int RN_LSB      = 5,
    parameter int RM_LSB      = 16,
    parameter int RD_LSB      = 0,
    parameter int ZERO_REG    = 31,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic                   in_reg2loc,
    input  logic                   in_reg_write,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       ReadSelect1,
    output logic [SEL_W-1:0]       ReadSelect2,
    output logic [SEL_W-1:0]       WriteSelect,
    output logic                   out_reg_write,
    output logic [INSTR_W-1:0]     out_instr,
    input  logic                   wb_valid,
    input  logic [SEL_W-1:0]       wb_sel,
    output logic [(2**SEL_W)-1:0]  busy_vec,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int NUM_REGS = 2**SEL_W;
    localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(ZERO_REG);
    localparam logic [NUM_REGS-1:0] ONE_BIT = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0]    src1;
    logic [SEL_W-1:0]    src2;
    logic [SEL_W-1:0]    dst;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic                hazard;
    logic                accept;

    assign src1 = in_instr[RN_LSB +: SEL_W];
    assign src2 = in_reg2loc ? in_instr[RD_LSB +: SEL_W] : in_instr[RM_LSB +: SEL_W];
    assign dst  = in_instr[RD_LSB +: SEL_W];

    assign busy_vec = busy;

    always_comb begin
        clr_mask = '0;
        if (wb_valid && (wb_sel != ZERO_SEL)) begin
            clr_mask = ONE_BIT << wb_sel;
        end
    end

`ifdef REGSEL_WB_BYPASS_EN
    assign busy_eff = busy & ~clr_mask;
`else
    assign busy_eff = busy;
`endif

    // XZR never participates in hazards, whatever its scoreboard bit says.
    always_comb begin
        hazard = 1'b0;
        if ((src1 != ZERO_SEL) && busy_eff[src1]) begin
            hazard = 1'b1;
        end
        if ((src2 != ZERO_SEL) && busy_eff[src2]) begin
            hazard = 1'b1;
        end
        if (in_reg_write && (dst != ZERO_SEL) && busy_eff[dst]) begin
            hazard = 1'b1;
        end
    end

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        set_mask = '0;
        if (accept && in_reg_write && (dst != ZERO_SEL)) begin
            set_mask = ONE_BIT << dst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            ReadSelect1   <= '0;
            ReadSelect2   <= '0;
            WriteSelect   <= '0;
            out_reg_write <= 1'b0;
            out_instr     <= '0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            ReadSelect1   <= src1;
            ReadSelect2   <= src2;
            WriteSelect   <= dst;
            out_reg_write <= in_reg_write;
            out_instr     <= in_instr;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    // Set is applied after clear so a new writer keeps ownership on a same-cycle retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regsel_decode_pipe.sv
// Directed self-checking bench for regsel_decode_pipe; expectations adapt when REGSEL_WB_BYPASS_EN is defined.
module tb_regsel_decode_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_reg2loc;
    logic        in_reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  ReadSelect1;
    logic [4:0]  ReadSelect2;
    logic [4:0]  WriteSelect;
    logic        out_reg_write;
    logic [31:0] out_instr;
    logic        wb_valid;
    logic [4:0]  wb_sel;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;

    int compared = 0;
    int mismatched = 0;
    int exp_stall;

    regsel_decode_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_reg2loc(in_reg2loc), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2), .WriteSelect(WriteSelect),
        .out_reg_write(out_reg_write), .out_instr(out_instr),
        .wb_valid(wb_valid), .wb_sel(wb_sel),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
        return {11'b10001011000, rm, 6'b000000, rn, rd};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic r2l, input logic rw);
        in_valid     = v;
        in_instr     = instr;
        in_reg2loc   = r2l;
        in_reg_write = rw;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        wb_valid = 1'b0;
        wb_sel = '0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_busy", busy_vec, 32'd0);
        checkOutput("rst_stall", {16'b0, stall_cnt}, 32'd0);
        checkOutput("rst_rs1", {27'b0, ReadSelect1}, 32'd0);
        rst = 1'b0;
        step();

        // ADD X6, X4, X5
        applyStimulus(1'b1, 32'b10001011000_00101_000000_00100_00110, 1'b0, 1'b1);
        checkOutput("add_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        checkOutput("add_out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("add_rs1", {27'b0, ReadSelect1}, 32'd4);
        checkOutput("add_rs2", {27'b0, ReadSelect2}, 32'd5);
        checkOutput("add_ws", {27'b0, WriteSelect}, 32'd6);
        checkOutput("add_busy", busy_vec, 32'h0000_0040);
        checkOutput("add_rw", {31'b0, out_reg_write}, 32'd1);
        checkOutput("add_instr", out_instr, 32'b10001011000_00101_000000_00100_00110);

        // RAW on X6
        applyStimulus(1'b1, mk(5'd1, 5'd6, 5'd8), 1'b0, 1'b1);
        checkOutput("raw_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        checkOutput("raw_drain", {31'b0, out_valid}, 32'd0);
        checkOutput("raw_stall1", {16'b0, stall_cnt}, 32'd1);
        step();
        checkOutput("raw_stall2", {16'b0, stall_cnt}, 32'd2);
        wb_valid = 1'b1;
        wb_sel = 5'd6;
        #1;
`ifdef REGSEL_WB_BYPASS_EN
        checkOutput("wb_bypass_ready", {31'b0, in_ready}, 32'd1);
        step();
        wb_valid = 1'b0;
        exp_stall = 2;
`else
        checkOutput("wb_nobypass_ready", {31'b0, in_ready}, 32'd0);
        step();
        wb_valid = 1'b0;
        checkOutput("wb_clear", busy_vec, 32'd0);
        #1;
        checkOutput("wb_after_ready", {31'b0, in_ready}, 32'd1);
        step();
        exp_stall = 3;
`endif
        checkOutput("raw_acc_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("raw_acc_rs1", {27'b0, ReadSelect1}, 32'd6);
        checkOutput("raw_acc_busy", busy_vec, 32'h0000_0100);
        checkOutput("raw_acc_stall", {16'b0, stall_cnt}, exp_stall);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        wb_valid = 1'b1;
        wb_sel = 5'd8;
        step();
        wb_valid = 1'b0;
        checkOutput("idle_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("idle_busy", busy_vec, 32'd0);

        // Store-style word: Reg2Loc picks Rt, then Rm
        applyStimulus(1'b1, 32'b11110010100_0000000000000100_00010, 1'b1, 1'b0);
        step();
        checkOutput("st_r2l1_rs2", {27'b0, ReadSelect2}, 32'd2);
        checkOutput("st_r2l1_rs1", {27'b0, ReadSelect1}, 32'd4);
        checkOutput("st_busy", busy_vec, 32'd0);
        applyStimulus(1'b1, 32'b11110010100_0000000000000100_00010, 1'b0, 1'b0);
        step();
        checkOutput("st_r2l0_rs2", {27'b0, ReadSelect2}, 32'd0);

        // XZR as destination and as source
        applyStimulus(1'b1, mk(5'd2, 5'd1, 5'd31), 1'b0, 1'b1);
        step();
        checkOutput("xzr_dst_busy", busy_vec, 32'd0);
        checkOutput("xzr_dst_ws", {27'b0, WriteSelect}, 32'd31);
        applyStimulus(1'b1, mk(5'd31, 5'd31, 5'd3), 1'b0, 1'b1);
        wb_valid = 1'b1;
        wb_sel = 5'd31;
        #1;
        checkOutput("xzr_src_ready", {31'b0, in_ready}, 32'd1);
        step();
        wb_valid = 1'b0;
        checkOutput("xzr_src_busy", busy_vec, 32'h0000_0008);
        checkOutput("xzr_src_rs1", {27'b0, ReadSelect1}, 32'd31);

        // Output back-pressure
        out_ready = 1'b0;
        applyStimulus(1'b1, mk(5'd2, 5'd1, 5'd4), 1'b0, 1'b0);
        checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_ws", {27'b0, WriteSelect}, 32'd3);
            checkOutput("bp_rs1", {27'b0, ReadSelect1}, 32'd31);
        end
        checkOutput("bp_stall", {16'b0, stall_cnt}, exp_stall);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
        step();
        checkOutput("bp_rel_ws", {27'b0, WriteSelect}, 32'd4);
        checkOutput("bp_rel_rs1", {27'b0, ReadSelect1}, 32'd1);
        checkOutput("bp_rel_rs2", {27'b0, ReadSelect2}, 32'd2);

        // Same-cycle set and clear of X7
        applyStimulus(1'b1, mk(5'd2, 5'd1, 5'd7), 1'b0, 1'b1);
        wb_valid = 1'b1;
        wb_sel = 5'd7;
        #1;
        checkOutput("sc_ready", {31'b0, in_ready}, 32'd1);
        step();
        wb_valid = 1'b0;
        checkOutput("sc_busy", busy_vec, 32'h0000_0088);

        // Saturation of the stall counter
        applyStimulus(1'b1, mk(5'd1, 5'd7, 5'd9), 1'b0, 1'b0);
        checkOutput("sat_ready", {31'b0, in_ready}, 32'd0);
        repeat (65534 - exp_stall) step();
        checkOutput("sat_fffe", {16'b0, stall_cnt}, 32'h0000_FFFE);
        step();
        checkOutput("sat_ffff", {16'b0, stall_cnt}, 32'h0000_FFFF);
        step();
        checkOutput("sat_hold", {16'b0, stall_cnt}, 32'h0000_FFFF);

        // Asynchronous reset mid-stall
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("arst_busy", busy_vec, 32'd0);
        checkOutput("arst_stall", {16'b0, stall_cnt}, 32'd0);
        checkOutput("arst_rs1", {27'b0, ReadSelect1}, 32'd0);
        checkOutput("arst_rs2", {27'b0, ReadSelect2}, 32'd0);
        checkOutput("arst_ws", {27'b0, WriteSelect}, 32'd0);
        checkOutput("arst_instr", out_instr, 32'd0);
        checkOutput("arst_rw", {31'b0, out_reg_write}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
